// File: rtl/sram_sweep_if.sv
// Request/response bundle for the sram_sweep storage block.
// The requester drives the master side; the memory is the slave.
interface sram_sweep_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    Adress;
    logic [WIDTH-1:0] Din;
    logic             RW;
    logic             En;
    logic             Clr;
    logic [WIDTH-1:0] Dout;
    logic             Valid;
    logic             Busy;
    logic             Drop;

    modport master (
        output Adress, Din, RW, En, Clr,
        input  Dout, Valid, Busy, Drop
    );

    modport slave (
        input  Adress, Din, RW, En, Clr,
        output Dout, Valid, Busy, Drop
    );
endinterface

// File: rtl/sram_sweep.sv
// Single-port WIDTH x DEPTH SRAM with registered read, valid strobe and a
// clear sweep that zeroes the array after reset or on command.
module sram_sweep #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    sram_sweep_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_d;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             valid_q;
    logic             valid_d;
    logic             drop_q;
    logic             drop_d;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem [DEPTH];

    // Control registers; array contents are cleared by the sweep, not by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= CLEAR;
            ptr     <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Next-state and datapath decode; sweep outranks everything, then Clr, then En.
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        drop_d    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = bus.Adress;
        mem_wdata = bus.Din;

        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = ptr;
                mem_wdata = '0;
                ptr_d     = ptr + AW'(1);
                dout_d    = '0;
                drop_d    = bus.En;
                if (ptr == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.Clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    dout_d  = '0;
                    drop_d  = bus.En;
                end else if (bus.En && bus.RW) begin
                    mem_we = 1'b1;
                    dout_d = '0;
                end else if (bus.En) begin
                    dout_d  = mem[bus.Adress];
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign bus.Dout  = dout_q;
    assign bus.Valid = valid_q;
    assign bus.Drop  = drop_q;
    assign bus.Busy  = (state == CLEAR);
endmodule

// File: tb/tb_sram_sweep.sv
// Randomised scoreboard bench for sram_sweep (WIDTH=8, DEPTH=16) against a
// countdown-based behavioural model of the clear sweep and memory.
module tb_sram_sweep;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic             busy;
        logic             valid;
        logic             drop;
        logic [WIDTH-1:0] dout;
    } exp_t;

    logic CLK;
    logic RST;

    sram_sweep_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sram_sweep #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: sweep modelled as edges remaining, array as plain storage.
    int               sweep_left;
    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [WIDTH-1:0] model_dout;
    logic             model_valid;
    logic             model_drop;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic zero_model_mem();
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    endtask

    // Apply one cycle of inputs at the falling edge and predict the state after the next rising edge.
    task automatic step(input logic rst, input logic en, input logic rw, input logic clr,
                        input logic [3:0] a, input logic [WIDTH-1:0] d);
        exp_t e;
        @(negedge CLK);
        RST        = rst;
        bus.En     = en;
        bus.RW     = rw;
        bus.Clr    = clr;
        bus.Adress = a;
        bus.Din    = d;

        if (!rst) begin
            sweep_left  = int'(DEPTH);
            model_dout  = '0;
            model_valid = 1'b0;
            model_drop  = 1'b0;
            zero_model_mem();
        end else if (sweep_left > 0) begin
            sweep_left--;
            model_dout  = '0;
            model_valid = 1'b0;
            model_drop  = en;
        end else if (clr) begin
            sweep_left  = int'(DEPTH);
            zero_model_mem();
            model_dout  = '0;
            model_valid = 1'b0;
            model_drop  = en;
        end else if (en && rw) begin
            model_mem[a] = d;
            model_dout   = '0;
            model_valid  = 1'b0;
            model_drop   = 1'b0;
        end else if (en) begin
            model_dout  = model_mem[a];
            model_valid = 1'b1;
            model_drop  = 1'b0;
        end else begin
            model_valid = 1'b0;
            model_drop  = 1'b0;
        end

        e.busy  = (sweep_left > 0);
        e.valid = model_valid;
        e.drop  = model_drop;
        e.dout  = model_dout;
        exp_q.push_back(e);

        if (!rst) begin
            #1;
            check("async_reset_busy", int'(bus.Busy), 1);
            check("async_reset_valid", int'(bus.Valid), 0);
            check("async_reset_dout", int'(bus.Dout), 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic wr(input logic [3:0] a, input logic [WIDTH-1:0] d);
        step(1'b1, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b1, 1'b0, 1'b0, a, 8'h00);
    endtask

    // Monitor: one expected entry per rising edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("busy",  int'(bus.Busy),  int'(e.busy));
                check("valid", int'(bus.Valid), int'(e.valid));
                check("drop",  int'(bus.Drop),  int'(e.drop));
                check("dout",  int'(bus.Dout),  int'(e.dout));
            end
        end
    end

    initial begin
        RST        = 1'b0;
        bus.En     = 1'b0;
        bus.RW     = 1'b0;
        bus.Clr    = 1'b0;
        bus.Adress = '0;
        bus.Din    = '0;
        sweep_left  = int'(DEPTH);
        model_dout  = '0;
        model_valid = 1'b0;
        model_drop  = 1'b0;
        zero_model_mem();

        // Reset, then read every address through and past the sweep.
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 2 * int'(DEPTH); i++) rd(4'(i));

        // Write/readback, read-after-write, write then hold.
        wr(4'd3, 8'hA5);
        wr(4'd15, 8'h5A);
        rd(4'd3);
        rd(4'd15);
        idle(2);
        wr(4'd7, 8'h3C);
        rd(4'd7);
        idle(1);

        // Fill with 0xFF, Clr with a colliding read, then read everything back.
        for (int i = 0; i < int'(DEPTH); i++) wr(4'(i), 8'hFF);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 8'h00);
        for (int i = 0; i < int'(DEPTH); i++) idle(1);
        for (int i = 0; i < int'(DEPTH); i++) rd(4'(i));

        // Held write during a sweep is dropped until Busy falls.
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 8'h77);
        for (int i = 0; i < int'(DEPTH); i++) wr(4'd2, 8'h77);
        rd(4'd2);
        wr(4'd2, 8'h77);
        rd(4'd2);

        // Reset in the middle of a sweep restarts it from scratch.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        idle(int'(DEPTH) + 2);
        rd(4'd2);

        // Random traffic with occasional Clr and reset.
        for (int i = 0; i < 600; i++) begin
            logic rst_v;
            logic clr_v;
            rst_v = ($urandom_range(0, 199) != 0);
            clr_v = ($urandom_range(0, 29) == 0);
            step(rst_v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), clr_v,
                 4'($urandom_range(0, 15)), 8'($urandom));
        end

        idle(2);
        @(negedge CLK);
        @(negedge CLK);
        check("queue_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end
endmodule
